// File: rtl/mr1_mem_arbiter_pkg.sv
// Shared constants, command struct and store-lane helpers for the MR1 memory arbiter.
package mr1_mem_pkg;
  localparam logic SRC_INSTR = 1'b0;
  localparam logic SRC_DATA  = 1'b1;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_cmd_t;

  function automatic logic [3:0] size_addr_to_be(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SIZE_B:  be = 4'b0001 << addr_lo;
      SIZE_H:  be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] replicate_wdata(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] w;
    case (size)
      SIZE_B:  w = {4{data[7:0]}};
      SIZE_H:  w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction
endpackage

// File: rtl/mr1_mem_arbiter_if.sv
// Fetch, data-bus and memory-port signals of the arbiter; slave = arbiter, master = core/memory side.
interface mr1_mem_arbiter_if;
  logic        instr_req_valid;
  logic        instr_req_ready;
  logic [31:0] instr_req_addr;
  logic        instr_rsp_valid;
  logic [31:0] instr_rsp_data;
  logic        dbus_cmd_valid;
  logic        dbus_cmd_ready;
  logic        dbus_cmd_wr;
  logic [31:0] dbus_cmd_addr;
  logic [31:0] dbus_cmd_data;
  logic [1:0]  dbus_cmd_size;
  logic        dbus_rsp_valid;
  logic [31:0] dbus_rsp_data;
  logic        mem_cmd_valid;
  logic        mem_cmd_ready;
  logic        mem_cmd_wr;
  logic [31:0] mem_cmd_addr;
  logic [31:0] mem_cmd_wdata;
  logic [3:0]  mem_cmd_be;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        err_unexpected_rsp;

  modport slave (
    input  instr_req_valid, instr_req_addr,
    input  dbus_cmd_valid, dbus_cmd_wr, dbus_cmd_addr, dbus_cmd_data, dbus_cmd_size,
    input  mem_cmd_ready, mem_rsp_valid, mem_rsp_data,
    output instr_req_ready, instr_rsp_valid, instr_rsp_data,
    output dbus_cmd_ready, dbus_rsp_valid, dbus_rsp_data,
    output mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_wdata, mem_cmd_be,
    output err_unexpected_rsp
  );

  modport master (
    output instr_req_valid, instr_req_addr,
    output dbus_cmd_valid, dbus_cmd_wr, dbus_cmd_addr, dbus_cmd_data, dbus_cmd_size,
    output mem_cmd_ready, mem_rsp_valid, mem_rsp_data,
    input  instr_req_ready, instr_rsp_valid, instr_rsp_data,
    input  dbus_cmd_ready, dbus_rsp_valid, dbus_rsp_data,
    input  mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_wdata, mem_cmd_be,
    input  err_unexpected_rsp
  );
endinterface

// File: rtl/mr1_mem_arbiter_src_fifo.sv
// 1-bit source-ID FIFO remembering which requester issued each outstanding read.
module mr1_src_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          din,
  input  logic          pop,
  output logic          head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr, rd_ptr;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mr1_mem_arbiter.sv
// Shares one memory port between MR1 fetch and data bus: data priority with a fetch
// starvation bound, grant lock on stall, read gating and in-order response routing.
module mr1_mem_arbiter
  import mr1_mem_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 3
) (
  input logic              clk,
  input logic              reset,
  mr1_mem_arbiter_if.slave bus
);
  localparam int         CW    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic          lock_q, lock_src_q, sel, req_valid, gated, cmd_hs;
  logic          push, pop, head, full, empty, err_q;
  logic [3:0]    starve_q;
  logic [CW-1:0] count;
  mem_cmd_t      cmd;

  always_comb begin
    sel = SRC_INSTR;
    if (lock_q)
      sel = lock_src_q;
    else if (bus.dbus_cmd_valid && !(bus.instr_req_valid && starve_q == LIMIT))
      sel = SRC_DATA;
  end

  always_comb begin
    cmd       = '0;
    req_valid = 1'b0;
    if (sel == SRC_DATA) begin
      req_valid = bus.dbus_cmd_valid;
      cmd.wr    = bus.dbus_cmd_wr;
      cmd.addr  = bus.dbus_cmd_addr & ~32'h3;
      cmd.be    = bus.dbus_cmd_wr ? size_addr_to_be(bus.dbus_cmd_size, bus.dbus_cmd_addr[1:0]) : 4'hf;
      cmd.wdata = replicate_wdata(bus.dbus_cmd_size, bus.dbus_cmd_data);
    end else begin
      req_valid = bus.instr_req_valid;
      cmd.addr  = bus.instr_req_addr & ~32'h3;
      cmd.be    = 4'hf;
    end
  end

  // Reads wait for a free slot; a response popping this cycle does not free one yet.
  assign gated  = !cmd.wr && full;
  assign cmd_hs = bus.mem_cmd_valid && bus.mem_cmd_ready;
  assign push   = cmd_hs && !cmd.wr;
  assign pop    = bus.mem_rsp_valid && !empty;

  assign bus.mem_cmd_valid   = req_valid && !gated;
  assign bus.mem_cmd_wr      = cmd.wr;
  assign bus.mem_cmd_addr    = cmd.addr;
  assign bus.mem_cmd_wdata   = cmd.wdata;
  assign bus.mem_cmd_be      = cmd.be;
  assign bus.instr_req_ready = cmd_hs && (sel == SRC_INSTR);
  assign bus.dbus_cmd_ready  = cmd_hs && (sel == SRC_DATA);

  assign bus.instr_rsp_valid    = pop && (head == SRC_INSTR);
  assign bus.dbus_rsp_valid     = pop && (head == SRC_DATA);
  assign bus.instr_rsp_data     = bus.mem_rsp_data;
  assign bus.dbus_rsp_data      = bus.mem_rsp_data;
  assign bus.err_unexpected_rsp = err_q;

  mr1_src_fifo #(.DEPTH(MAX_OUTSTANDING), .CW(CW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (sel),
    .pop   (pop),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q     <= 1'b0;
      lock_src_q <= SRC_INSTR;
      starve_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      // A stalled command keeps its grant until memory accepts it.
      lock_q     <= bus.mem_cmd_valid && !bus.mem_cmd_ready;
      lock_src_q <= sel;
      if (!bus.instr_req_valid || bus.instr_req_ready)
        starve_q <= '0;
      else if (bus.dbus_cmd_ready && starve_q != LIMIT)
        starve_q <= starve_q + 1'b1;
      if (bus.mem_rsp_valid && empty)
        err_q <= 1'b1;
    end
  end

  assert property (@(posedge clk) disable iff (reset) count <= CW'(MAX_OUTSTANDING));
endmodule

// File: tb/tb_mr1_mem_arbiter.sv
// Randomised and directed bench for mr1_mem_arbiter against a queue-based reference model.
module tb_mr1_mem_arbiter;
  localparam int MAXO = 2;
  localparam int LIM  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mr1_mem_arbiter_if b();

  mr1_mem_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIM)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b.slave)
  );

  int chk_n = 0, pass_n = 0, cyc = 0;

  // reference model state
  bit srcq[$];
  int starve = 0;
  bit locked = 0, lock_d = 0, err_m = 0;
  bit m_ihs, m_dhs;

  // DUT outputs captured at the last compare point
  logic a_mv, a_ir, a_dr, a_irv, a_drv, a_err, a_wr;
  logic [31:0] a_addr, a_wdata, a_ird, a_drd;
  logic [3:0] a_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_n++;
    if (act !== exp) $display("FAIL %s: got %0h, need %0h @cycle %0d", name, act, exp, cyc);
    else pass_n++;
  endtask

  task automatic step();
    bit full, sel_d, rd, e_mv, e_ir, e_dr, e_irv, e_drv, e_wr;
    logic [31:0] e_addr, e_wdata;
    logic [3:0] e_be;
    @(negedge clk);
    a_mv = b.mem_cmd_valid;  a_ir = b.instr_req_ready; a_dr = b.dbus_cmd_ready;
    a_irv = b.instr_rsp_valid; a_drv = b.dbus_rsp_valid; a_err = b.err_unexpected_rsp;
    a_wr = b.mem_cmd_wr; a_addr = b.mem_cmd_addr; a_wdata = b.mem_cmd_wdata; a_be = b.mem_cmd_be;
    a_ird = b.instr_rsp_data; a_drd = b.dbus_rsp_data;

    full = (srcq.size() >= MAXO);
    if (locked) sel_d = lock_d;
    else sel_d = b.dbus_cmd_valid && !(b.instr_req_valid && starve == LIM);
    rd   = !sel_d || !b.dbus_cmd_wr;
    e_mv = (sel_d ? b.dbus_cmd_valid : b.instr_req_valid) && !(rd && full);
    e_ir = e_mv && !sel_d && b.mem_cmd_ready;
    e_dr = e_mv && sel_d && b.mem_cmd_ready;
    e_irv = b.mem_rsp_valid && srcq.size() > 0 && srcq[0] == 1'b0;
    e_drv = b.mem_rsp_valid && srcq.size() > 0 && srcq[0] == 1'b1;
    if (sel_d) begin
      e_wr = b.dbus_cmd_wr;
      e_addr = b.dbus_cmd_addr & ~32'h3;
      e_be = 4'hf;
      e_wdata = b.dbus_cmd_data;
      if (e_wr && b.dbus_cmd_size == 2'd0) begin
        e_be = 4'b0001 << b.dbus_cmd_addr[1:0];
        e_wdata = {24'h0, b.dbus_cmd_data[7:0]} * 32'h01010101;
      end else if (e_wr && b.dbus_cmd_size == 2'd1) begin
        e_be = b.dbus_cmd_addr[1] ? 4'b1100 : 4'b0011;
        e_wdata = {16'h0, b.dbus_cmd_data[15:0]} * 32'h00010001;
      end
    end else begin
      e_wr = 1'b0; e_addr = b.instr_req_addr & ~32'h3; e_be = 4'hf; e_wdata = 32'h0;
    end

    chk("mem_cmd_valid", 32'(a_mv), 32'(e_mv));
    chk("instr_req_ready", 32'(a_ir), 32'(e_ir));
    chk("dbus_cmd_ready", 32'(a_dr), 32'(e_dr));
    chk("instr_rsp_valid", 32'(a_irv), 32'(e_irv));
    chk("dbus_rsp_valid", 32'(a_drv), 32'(e_drv));
    chk("err_unexpected_rsp", 32'(a_err), 32'(err_m));
    if (e_mv) begin
      chk("mem_cmd_wr", 32'(a_wr), 32'(e_wr));
      chk("mem_cmd_addr", a_addr, e_addr);
      chk("mem_cmd_be", 32'(a_be), 32'(e_be));
      if (e_wr) chk("mem_cmd_wdata", a_wdata, e_wdata);
    end
    if (e_irv) chk("instr_rsp_data", a_ird, b.mem_rsp_data);
    if (e_drv) chk("dbus_rsp_data", a_drd, b.mem_rsp_data);

    m_ihs = e_ir;
    m_dhs = e_dr;
    if (reset) begin
      srcq.delete(); starve = 0; locked = 0; err_m = 0;
    end else begin
      if (b.mem_rsp_valid) begin
        if (srcq.size() > 0) void'(srcq.pop_front());
        else err_m = 1;
      end
      if (e_mv && b.mem_cmd_ready && rd) srcq.push_back(sel_d);
      if (!b.instr_req_valid || e_ir) starve = 0;
      else if (e_dr && starve < LIM) starve++;
      if (e_mv && !b.mem_cmd_ready) begin locked = 1; lock_d = sel_d; end
      else if (e_mv) locked = 0;
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    b.instr_req_valid = 0; b.dbus_cmd_valid = 0; b.mem_rsp_valid = 0;
  endtask

  task automatic drain();
    idle();
    for (int n = 0; n < 10 && srcq.size() > 0; n++) begin
      b.mem_rsp_valid = 1; b.mem_rsp_data = $urandom;
      step();
    end
    b.mem_rsp_valid = 0;
  endtask

  task automatic dcmd(input logic wr, input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    b.dbus_cmd_valid = 1; b.dbus_cmd_wr = wr; b.dbus_cmd_addr = addr;
    b.dbus_cmd_data = data; b.dbus_cmd_size = size;
  endtask

  initial begin
    logic [31:0] vals [3];
    logic [31:0] addrs_seen[$], data_seen[$];
    int due[$];
    int idx, rsp_i, drv_cnt;
    logic [7:0] pat;
    bit ip, dp;

    idle();
    b.instr_req_addr = 0; b.dbus_cmd_wr = 0; b.dbus_cmd_addr = 0; b.dbus_cmd_data = 0;
    b.dbus_cmd_size = 0; b.mem_cmd_ready = 0; b.mem_rsp_data = 0;
    @(posedge clk); #1;

    // reset state
    step();
    chk("rst_mem_cmd_valid", 32'(a_mv), 0);
    chk("rst_err", 32'(a_err), 0);
    chk("rst_fifo_count", 32'(u_dut.u_fifo.count), 0);
    reset = 0;
    step();

    // fetch-only stream, responses two cycles after acceptance
    vals = '{32'h11, 32'h22, 32'h33};
    idx = 0; rsp_i = 0; drv_cnt = 0;
    b.mem_cmd_ready = 1;
    for (int n = 0; n < 30 && data_seen.size() < 3; n++) begin
      b.instr_req_valid = (idx < 3);
      b.instr_req_addr = 32'(idx * 4);
      b.mem_rsp_valid = (due.size() > 0 && due[0] == cyc);
      b.mem_rsp_data = vals[rsp_i % 3];
      step();
      if (a_ir) addrs_seen.push_back(a_addr);
      if (a_irv) data_seen.push_back(a_ird);
      if (a_drv) drv_cnt++;
      if (b.mem_rsp_valid) begin void'(due.pop_front()); rsp_i++; end
      if (m_ihs) begin due.push_back(cyc + 1); idx++; end
    end
    idle();
    chk("fetch_rsp_count", 32'(data_seen.size()), 3);
    chk("fetch_dbus_rsp", 32'(drv_cnt), 0);
    for (int i = 0; i < 3; i++) begin
      if (i < addrs_seen.size()) chk($sformatf("fetch_addr%0d", i), addrs_seen[i], 32'(i * 4));
      if (i < data_seen.size()) chk($sformatf("fetch_data%0d", i), data_seen[i], vals[i]);
    end
    drain();

    // contention: stores vs. fetch, expected grants D D D I D D D I
    pat = 8'b1110_1110;
    b.instr_req_valid = 1; b.instr_req_addr = 32'h44;
    for (int k = 0; k < 8; k++) begin
      dcmd(1, $urandom, $urandom, 2'd2);
      b.mem_rsp_valid = (srcq.size() > 0);
      step();
      chk($sformatf("grant%0d_d", k), 32'(a_dr), 32'(pat[7-k]));
      chk($sformatf("grant%0d_i", k), 32'(a_ir), 32'(!pat[7-k]));
    end
    drain();
    step();

    // stall lock: data load held while fetch waits
    dcmd(0, 32'h100, 0, 2'd2);
    b.instr_req_valid = 1; b.instr_req_addr = 32'h40; b.mem_cmd_ready = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("lock_addr", a_addr, 32'h100);
      chk("lock_wr", 32'(a_wr), 0);
      chk("lock_iready", 32'(a_ir), 0);
    end
    b.mem_cmd_ready = 1;
    step();
    chk("lock_hs_dready", 32'(a_dr), 1);
    chk("lock_hs_iready", 32'(a_ir), 0);
    b.dbus_cmd_valid = 0;
    step();
    chk("lock_after_iready", 32'(a_ir), 1);
    drain();

    // store lanes
    dcmd(1, 32'h203, 32'hAB, 2'd0);
    step();
    chk("sb_be", 32'(a_be), 32'h8);
    chk("sb_wdata", a_wdata, 32'hABABABAB);
    chk("sb_addr", a_addr, 32'h200);
    dcmd(1, 32'h202, 32'h1234, 2'd1);
    step();
    chk("sh_be", 32'(a_be), 32'hC);
    chk("sh_wdata", a_wdata, 32'h12341234);
    dcmd(1, 32'h204, 32'hDEADBEEF, 2'd2);
    step();
    chk("sw_be", 32'(a_be), 32'hF);
    chk("sw_wdata", a_wdata, 32'hDEADBEEF);
    idle();
    chk("store_no_push", 32'(u_dut.u_fifo.count), 0);

    // outstanding limit with interleaved I, D, I
    b.instr_req_valid = 1; b.instr_req_addr = 32'h10;
    step();
    b.instr_req_valid = 0; dcmd(0, 32'h20, 0, 2'd2);
    step();
    b.dbus_cmd_valid = 0; b.instr_req_valid = 1; b.instr_req_addr = 32'h30;
    step();
    chk("full_iready", 32'(a_ir), 0);
    chk("full_mvalid", 32'(a_mv), 0);
    b.mem_rsp_valid = 1; b.mem_rsp_data = 32'hA1;
    step();
    chk("pop_same_cycle_iready", 32'(a_ir), 0);
    chk("route0_i", 32'(a_irv), 1);
    chk("route0_d", 32'(a_drv), 0);
    chk("route0_data", a_ird, 32'hA1);
    b.mem_rsp_valid = 0;
    step();
    chk("pop_next_cycle_iready", 32'(a_ir), 1);
    b.instr_req_valid = 0; b.mem_rsp_valid = 1; b.mem_rsp_data = 32'hB2;
    step();
    chk("route1_d", 32'(a_drv), 1);
    chk("route1_i", 32'(a_irv), 0);
    chk("route1_data", a_drd, 32'hB2);
    b.mem_rsp_data = 32'hC3;
    step();
    chk("route2_i", 32'(a_irv), 1);
    chk("route2_data", a_ird, 32'hC3);
    idle();

    // unexpected response, then reset with reads outstanding
    b.mem_rsp_valid = 1; b.mem_rsp_data = 32'h55;
    step();
    chk("unexp_irv", 32'(a_irv), 0);
    chk("unexp_drv", 32'(a_drv), 0);
    b.mem_rsp_valid = 0;
    step();
    chk("err_set", 32'(a_err), 1);
    step();
    chk("err_sticky", 32'(a_err), 1);
    b.instr_req_valid = 1; b.instr_req_addr = 32'h80;
    step();
    b.instr_req_valid = 0; dcmd(0, 32'h90, 0, 2'd2);
    step();
    idle();
    chk("pre_reset_count", 32'(u_dut.u_fifo.count), 2);
    reset = 1;
    step();
    reset = 0;
    chk("post_reset_count", 32'(u_dut.u_fifo.count), 0);
    step();
    chk("post_reset_err", 32'(a_err), 0);
    chk("post_reset_mvalid", 32'(a_mv), 0);
    chk("post_reset_irv", 32'(a_irv), 0);
    b.mem_rsp_valid = 1;
    step();
    b.mem_rsp_valid = 0;
    step();
    chk("stale_rsp_err", 32'(a_err), 1);
    reset = 1;
    step();
    reset = 0;

    // randomised traffic
    ip = 0; dp = 0;
    for (int n = 0; n < 2000; n++) begin
      if (!ip && $urandom_range(2) == 0) begin
        ip = 1; b.instr_req_addr = $urandom & ~32'h3;
      end
      if (!dp && $urandom_range(2) == 0) begin
        dp = 1;
        dcmd(1'($urandom_range(1)), $urandom, $urandom, 2'($urandom_range(3)));
      end
      b.instr_req_valid = ip;
      b.dbus_cmd_valid = dp;
      b.mem_cmd_ready = ($urandom_range(3) != 0);
      b.mem_rsp_valid = (srcq.size() > 0) && ($urandom_range(1) == 1);
      b.mem_rsp_data = $urandom;
      step();
      if (m_ihs) ip = 0;
      if (m_dhs) dp = 0;
    end

    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end
endmodule

// File: doc/mr1_mem_arbiter.md
Name: mr1_mem_arbiter

Overview:
- Shares one memory port between the MR1 instruction-fetch interface and the MR1 data-bus interface.
- Arbitrates commands with data priority plus a starvation bound for fetch.
- Tracks outstanding reads in order and routes each memory response back to the requester that issued it.
- Sits between the MR1 core and the single-port memory, or the formal memory model, in the top level.

Parameters:
- MAX_OUTSTANDING, 4, maximum reads in flight (1..8). Sizes the source-ID FIFO.
- STARVE_LIMIT, 3, consecutive data grants allowed while fetch is waiting before fetch is forced (1..15).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- instr_req_valid  in  1  fetch request
- instr_req_ready  out  1  fetch request accepted
- instr_req_addr  in  32  fetch address, word aligned
- instr_rsp_valid  out  1  fetch data valid
- instr_rsp_data  out  32  fetch data
- dbus_cmd_valid  in  1  data command
- dbus_cmd_ready  out  1  data command accepted
- dbus_cmd_wr  in  1  1 = store, 0 = load
- dbus_cmd_addr  in  32  byte address
- dbus_cmd_data  in  32  store data, LSB-aligned
- dbus_cmd_size  in  2  0 = byte, 1 = half, 2 = word
- dbus_rsp_valid  out  1  load data valid
- dbus_rsp_data  out  32  raw memory word
- mem_cmd_valid  out  1  memory command
- mem_cmd_ready  in  1  memory accepts
- mem_cmd_wr  out  1  store
- mem_cmd_addr  out  32  word address (addr[1:0] forced to 0)
- mem_cmd_wdata  out  32  lane-replicated store data
- mem_cmd_be  out  4  byte enables
- mem_rsp_valid  in  1  read data return, in order
- mem_rsp_data  in  32  read data
- err_unexpected_rsp  out  1  sticky flag: response arrived with no read outstanding

Behaviour:
- **Reset values.** All valid/ready outputs 0, err_unexpected_rsp 0, FIFO empty, grant unlocked, starve counter 0.
- **Command path latency.** Zero cycles: mem_cmd_* are driven combinationally from the selected requester.
- **Arbitration (unlocked).**
  - Data wins when both are valid.
  - Exception: fetch wins when starve_cnt == STARVE_LIMIT.
- **starve_cnt.**
  - Increments on each data handshake while instr_req_valid=1.
  - Clears on any fetch handshake, or when instr_req_valid=0.
  - Saturates at STARVE_LIMIT.
- **Grant lock.** If mem_cmd_valid=1 and mem_cmd_ready=0, the grant and payload are held until the handshake. Arbitration resumes the cycle after the handshake.
- **Read gating.** A read (any fetch, or a data load) may only be presented when outstanding count < MAX_OUTSTANDING.
  - A simultaneous pop does not free a slot in the same cycle.
  - Stores are never gated by the FIFO.
- **Requester ready.** requester_ready = granted & mem_cmd_ready & not gated.
- **Source-ID FIFO.**
  - Each accepted read pushes one bit: 0 = fetch, 1 = data.
  - Each mem_rsp_valid pops the head.
  - Pointers wrap modulo MAX_OUTSTANDING.
  - Push and pop in the same cycle keep the count unchanged.
- **Response routing.** Combinational, zero latency.
  - instr_rsp_valid = mem_rsp_valid & !empty & head==0.
  - dbus_rsp_valid = mem_rsp_valid & !empty & head==1.
  - Both data outputs equal mem_rsp_data.
  - mem_rsp_valid while the FIFO is empty: no pop, no valid out, err_unexpected_rsp set until reset.
- **Store lanes.**
  - Byte: be = 1<<addr[1:0]; wdata = {4{data[7:0]}}.
  - Half: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{data[15:0]}}.
  - Word: be = 4'b1111; wdata = data.
  - Size 3 is treated as word.
  - Reads drive be = 4'b1111.
- **Misalignment.** No checking (the core guarantees alignment).
- **Reset mid-operation.**
  - Clears the FIFO and lock.
  - Responses for pre-reset reads that arrive after reset set err_unexpected_rsp. The system must quiesce memory during reset.

Decomposition:
- **Package mr1_mem_pkg:**
  - SRC_INSTR / SRC_DATA constants.
  - Size encodings SIZE_B / SIZE_H / SIZE_W.
  - Function size_addr_to_be.
  - Function replicate_wdata.
- **Sub-module mr1_src_fifo.** A 1-bit-wide, depth-parameterised FIFO with push, pop, head, count, full and empty.

Test Plan:
- **Fetch-only stream.** instr_req_valid held at 1, addrs 0x0, 0x4, 0x8; mem_cmd_ready=1; rsp returns 2 cycles later with 0x11, 0x22, 0x33 → mem_cmd_addr follows the addrs; instr_rsp_data 0x11, 0x22, 0x33 in order; dbus_rsp_valid never asserted.
- **Contention and starvation.** Both valid continuously, STARVE_LIMIT=3 → grant sequence D, D, D, I, D, D, D, I.
- **Stall lock.** Data load to 0x100 presented with mem_cmd_ready=0 for 3 cycles while fetch also raises valid → mem_cmd_addr stays 0x100 and mem_cmd_wr=0 throughout; instr_req_ready=0 until the cycle after the handshake.
- **Store lanes.** sb 0xAB to 0x203 → be=1000, wdata=0xABABABAB. sh 0x1234 to 0x202 → be=1100, wdata=0x12341234. sw to 0x204 → be=1111. No FIFO push for any of them.
- **Outstanding limit.** MAX_OUTSTANDING=2 with responses withheld → a 3rd read sees ready=0. Releasing one response allows the 3rd read on the next cycle, not the same cycle. Interleaved I, D, I reads route back as I, D, I.
- **Error and reset.** mem_rsp_valid with the FIFO empty → err_unexpected_rsp=1 and stays set; both rsp valids stay 0. Assert reset with 2 reads outstanding → count=0, err cleared, all outputs at reset values the next cycle.
